// File: rtl/seq_booth_multiplier_pkg.sv
// Shared constants and types for the radix-2 Booth multiplier.
// Widths, step count, FSM encoding and Booth pair codes.
package seq_booth_multiplier_pkg;

   localparam int WIDTH       = 16;
   localparam int EXT_WIDTH   = 17;
   localparam int BOOTH_STEPS = 17;
   localparam int CNT_WIDTH   = 5;

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_e;

   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/seq_booth_multiplier_if.sv
// Start/busy/done handshake plus operand and HI/LO result bus.
// The control unit is master; the multiplier is slave.
interface seq_booth_multiplier_if #(
   parameter int WIDTH = 16
);

   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, is_signed, a, b,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, is_signed, a, b,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/seq_booth_multiplier_addsub.sv
// Ripple-carry add/subtract: sum = x + (y ^ {W{sub}}) + sub.
// Carry out is dropped; results wrap modulo 2^W.
module booth_addsub_17 #(
   parameter int W = 17
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         sub,
   output logic [W-1:0] sum
);

   logic [W-1:0] yx;
   logic [W-1:0] carry;

   assign carry[0] = sub;

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign yx[i]  = y[i] ^ sub;
      assign sum[i] = x[i] ^ yx[i] ^ carry[i];
      if (i < W - 1) begin : g_c
         assign carry[i+1] = (x[i] & yx[i]) |
                             (carry[i] & (x[i] ^ yx[i]));
      end
   end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier for MULT/MULTU.
// One add/sub plus arithmetic shift per cycle over WIDTH+1 steps.
module seq_booth_multiplier #(
   parameter int WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   seq_booth_multiplier_if.slave bus
);

   import seq_booth_multiplier_pkg::*;

   localparam int EXT   = WIDTH + 1;
   localparam int STEPS = WIDTH + 1;
   localparam int CW    = $clog2(WIDTH + 2);

   state_e           state_q;
   logic [EXT-1:0]   a_q;
   logic [EXT-1:0]   q_q;
   logic [EXT-1:0]   m_q;
   logic             qm1_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             busy_q;
   logic             done_q;

   logic [1:0]       pair;
   logic             sub;
   logic [EXT-1:0]   sum;
   logic [EXT-1:0]   a_acc;
   logic [EXT-1:0]   a_d;
   logic [EXT-1:0]   q_d;
   logic             qm1_d;
   logic [EXT-1:0]   m_ext;
   logic [EXT-1:0]   b_ext;

   assign m_ext = {bus.is_signed & bus.a[WIDTH-1], bus.a};
   assign b_ext = {bus.is_signed & bus.b[WIDTH-1], bus.b};

   assign pair = {q_q[0], qm1_q};
   assign sub  = (pair == BOOTH_SUB);

   booth_addsub_17 #(
      .W   (EXT)
   ) u_addsub (
      .x   (a_q),
      .y   (m_q),
      .sub (sub),
      .sum (sum)
   );

   always_comb begin
      a_acc = a_q;
      if (pair == BOOTH_ADD || pair == BOOTH_SUB) begin
         a_acc = sum;
      end
   end

   // Arithmetic shift of {A', Q, q_m1} by one.
   assign a_d   = {a_acc[EXT-1], a_acc[EXT-1:1]};
   assign q_d   = {a_acc[0], q_q[EXT-1:1]};
   assign qm1_d = q_q[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         q_q     <= '0;
         m_q     <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  a_q     <= '0;
                  q_q     <= b_ext;
                  qm1_q   <= 1'b0;
                  m_q     <= m_ext;
                  cnt_q   <= CW'(STEPS);
                  busy_q  <= 1'b1;
                  state_q <= CALC;
               end
            end
            CALC: begin
               a_q   <= a_d;
               q_q   <= q_d;
               qm1_q <= qm1_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  hi_q    <= {a_d[WIDTH-2:0], q_d[EXT-1]};
                  lo_q    <= q_d[WIDTH-1:0];
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed and random checks of seq_booth_multiplier
// against an integer-arithmetic product model.
module tb_seq_booth_multiplier;

   localparam int LAT = 17;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   seq_booth_multiplier_if #(.WIDTH(16)) mif ();

   seq_booth_multiplier #(
      .WIDTH (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (mif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic sgn,
                                         input logic [15:0] x,
                                         input logic [15:0] y);
      longint px;
      longint py;
      px = sgn ? longint'($signed(x)) : longint'(x);
      py = sgn ? longint'($signed(y)) : longint'(y);
      return 32'(px * py);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic sgn,
                         input logic [15:0] x,
                         input logic [15:0] y);
      int n;
      int bc;
      logic [31:0] p;
      p = model(sgn, x, y);
      mif.start     = 1'b1;
      mif.is_signed = sgn;
      mif.a         = x;
      mif.b         = y;
      tick();
      mif.start     = 1'b0;
      mif.is_signed = ~sgn;
      mif.a         = 16'($urandom);
      mif.b         = 16'($urandom);
      n  = 0;
      bc = 0;
      while (!mif.done && n < 40) begin
         if (mif.busy) bc++;
         tick();
         n++;
      end
      check("latency", 32'(n), 32'(LAT));
      check("busy_len", 32'(bc), 32'(LAT));
      check("hi", {16'h0, mif.hi}, {16'h0, p[31:16]});
      check("lo", {16'h0, mif.lo}, {16'h0, p[15:0]});
      check("busy_at_done", {31'h0, mif.busy}, 32'h0);
      tick();
      check("done_pulse", {31'h0, mif.done}, 32'h0);
   endtask

   initial begin
      logic [31:0] px;
      logic [31:0] py;
      logic        hold_ok;
      int          n;
      int          dcnt;

      tests         = 0;
      fails         = 0;
      rst_n         = 1'b0;
      mif.start     = 1'b0;
      mif.is_signed = 1'b0;
      mif.a         = '0;
      mif.b         = '0;
      #12;
      check("rst_busy", {31'h0, mif.busy}, 32'h0);
      check("rst_done", {31'h0, mif.done}, 32'h0);
      check("rst_hi", {16'h0, mif.hi}, 32'h0);
      check("rst_lo", {16'h0, mif.lo}, 32'h0);
      rst_n = 1'b1;
      tick();
      tick();
      check("idle_busy", {31'h0, mif.busy}, 32'h0);

      run_op(1'b0, 16'h0003, 16'h0005);
      run_op(1'b0, 16'hFFFF, 16'hFFFF);
      run_op(1'b1, 16'hFFFF, 16'hFFFF);
      run_op(1'b1, 16'h8000, 16'h8000);
      run_op(1'b1, 16'hFFFF, 16'h0002);
      run_op(1'b1, 16'h7FFF, 16'h8000);
      run_op(1'b0, 16'h0000, 16'hABCD);

      for (int i = 0; i < 16; i++) begin
         run_op(1'($urandom_range(0, 1)),
                16'($urandom), 16'($urandom));
      end

      // start pulsed mid-run must be ignored
      px = model(1'b1, 16'h1234, 16'hF00D);
      mif.start     = 1'b1;
      mif.is_signed = 1'b1;
      mif.a         = 16'h1234;
      mif.b         = 16'hF00D;
      tick();
      mif.start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      mif.start     = 1'b1;
      mif.is_signed = 1'b0;
      mif.a         = 16'h5555;
      mif.b         = 16'h0101;
      tick();
      mif.start = 1'b0;
      n = 5;
      while (!mif.done && n < 40) begin
         tick();
         n++;
      end
      check("ign_latency", 32'(n), 32'(LAT));
      check("ign_result", {mif.hi, mif.lo}, px);
      dcnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (mif.done) dcnt++;
      end
      check("ign_no_2nd_done", 32'(dcnt), 32'h0);

      // start held high: back-to-back operations
      px = model(1'b0, 16'hBEEF, 16'h0123);
      py = model(1'b1, 16'h8001, 16'h7FFE);
      mif.start     = 1'b1;
      mif.is_signed = 1'b0;
      mif.a         = 16'hBEEF;
      mif.b         = 16'h0123;
      n = 0;
      while (!mif.done && n < 40) begin
         tick();
         n++;
      end
      check("b2b_first", {mif.hi, mif.lo}, px);
      mif.is_signed = 1'b1;
      mif.a         = 16'h8001;
      mif.b         = 16'h7FFE;
      hold_ok = 1'b1;
      n = 0;
      while (n < 40) begin
         tick();
         n++;
         if (mif.done) break;
         if ({mif.hi, mif.lo} !== px) hold_ok = 1'b0;
      end
      check("b2b_period", 32'(n), 32'(LAT + 1));
      check("b2b_hold", {31'h0, hold_ok}, 32'h1);
      check("b2b_second", {mif.hi, mif.lo}, py);
      mif.start = 1'b0;
      tick();
      check("b2b_done_drop", {31'h0, mif.done}, 32'h0);

      // asynchronous reset mid-run
      mif.start     = 1'b1;
      mif.is_signed = 1'b0;
      mif.a         = 16'h4321;
      mif.b         = 16'h00FF;
      tick();
      mif.start = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", {31'h0, mif.busy}, 32'h0);
      check("mid_rst_done", {31'h0, mif.done}, 32'h0);
      check("mid_rst_hi", {16'h0, mif.hi}, 32'h0);
      check("mid_rst_lo", {16'h0, mif.lo}, 32'h0);
      #2;
      rst_n = 1'b1;
      tick();
      check("post_rst_idle", {31'h0, mif.busy}, 32'h0);
      run_op(1'b0, 16'h0007, 16'h0009);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
